// File: rtl/gpio_cfg_pkg.sv
// Shared constants and types for the per-pad GPIO configuration shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_cfg_pkg;

  localparam int CFG_WIDTH = 13;

  // Bit positions of the pad-control fields inside the configuration word
  localparam int CFG_MGMT_ENA = 0;
  localparam int CFG_OUTENB   = 1;
  localparam int CFG_HOLDOVER = 2;
  localparam int CFG_INENB    = 3;
  localparam int CFG_IB_MODE  = 4;
  localparam int CFG_ANA_EN   = 5;
  localparam int CFG_ANA_SEL  = 6;
  localparam int CFG_ANA_POL  = 7;
  localparam int CFG_SLOW     = 8;
  localparam int CFG_VTRIP    = 9;
  localparam int CFG_DM_LSB   = 10;
  localparam int DM_WIDTH     = 3;

  // Typical mask-programmed default: output buffer disabled, drive mode 001
  localparam logic [CFG_WIDTH-1:0] CFG_DEFAULT = 13'h0402;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2
  } cfg_state_t;

  // Decoded pad controls, one bundle so the decoder has a single output
  typedef struct packed {
    logic                mgmt_ena;
    logic                outenb;
    logic                holdover;
    logic                inenb;
    logic                ib_mode_sel;
    logic                ana_en;
    logic                ana_sel;
    logic                ana_pol;
    logic                slow_sel;
    logic                vtrip_sel;
    logic [DM_WIDTH-1:0] dm;
  } pad_ctrl_t;

  // Values driven to the pad before a configuration has been loaded:
  // both buffers disabled, everything else off
  localparam pad_ctrl_t PAD_SAFE = '{
    mgmt_ena:    1'b0,
    outenb:      1'b1,
    holdover:    1'b0,
    inenb:       1'b1,
    ib_mode_sel: 1'b0,
    ana_en:      1'b0,
    ana_sel:     1'b0,
    ana_pol:     1'b0,
    slow_sel:    1'b0,
    vtrip_sel:   1'b0,
    dm:          '0
  };

endpackage

// File: rtl/gpio_config_decode.sv
// Field extraction from the committed configuration word, forced to safe values until valid.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs continuously.
module gpio_config_decode
  import gpio_cfg_pkg::*;
(
  input  logic                 config_valid,
  input  logic [CFG_WIDTH-1:0] config_reg,
  output pad_ctrl_t            pad,
  output logic [CFG_WIDTH-1:0] gpio_config
);

  // Split the word into pad fields, or hold the pad in its safe state
  always_comb begin
    pad         = PAD_SAFE;
    gpio_config = '0;
    if (config_valid) begin
      gpio_config     = config_reg;
      pad.mgmt_ena    = config_reg[CFG_MGMT_ENA];
      pad.outenb      = config_reg[CFG_OUTENB];
      pad.holdover    = config_reg[CFG_HOLDOVER];
      pad.inenb       = config_reg[CFG_INENB];
      pad.ib_mode_sel = config_reg[CFG_IB_MODE];
      pad.ana_en      = config_reg[CFG_ANA_EN];
      pad.ana_sel     = config_reg[CFG_ANA_SEL];
      pad.ana_pol     = config_reg[CFG_ANA_POL];
      pad.slow_sel    = config_reg[CFG_SLOW];
      pad.vtrip_sel   = config_reg[CFG_VTRIP];
      pad.dm          = config_reg[CFG_DM_LSB +: DM_WIDTH];
    end
  end

endmodule

// File: rtl/gpio_config_shifter.sv
// Per-pad GPIO config: loads defaults after reset, takes a serial MSB-first reload, commits on exact bit count.
// Latency: committed word reaches the pad outputs one cycle after the load_strobe edge.
// Backpressure: none; strobes are accepted every cycle (dropped only in S_INIT or by priority restore > load > shift).
module gpio_config_shifter
  import gpio_cfg_pkg::*;
#(
  // Counter must be able to hold a value strictly above CFG_WIDTH so an
  // over-long stream saturates instead of wrapping back onto a valid count
  parameter int CNT_WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                  VPWR,
  inout  wire                  VGND,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CFG_WIDTH-1:0] gpio_defaults,
  input  logic                 serial_data_in,
  input  logic                 shift_en,
  input  logic                 load_strobe,
  input  logic                 restore,
  output logic                 serial_data_out,
  output logic [CFG_WIDTH-1:0] gpio_config,
  output logic                 config_valid,
  output logic                 load_done,
  output logic                 load_error,
  output logic                 mgmt_ena,
  output logic                 gpio_outenb,
  output logic                 gpio_holdover,
  output logic                 gpio_inenb,
  output logic                 gpio_ib_mode_sel,
  output logic                 gpio_ana_en,
  output logic                 gpio_ana_sel,
  output logic                 gpio_ana_pol,
  output logic                 gpio_slow_sel,
  output logic                 gpio_vtrip_sel,
  output logic [DM_WIDTH-1:0]  gpio_dm
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CFG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  cfg_state_t           state;
  logic [CFG_WIDTH-1:0] shift_reg;
  logic [CFG_WIDTH-1:0] config_reg;
  logic [CNT_WIDTH-1:0] bit_cnt;
  pad_ctrl_t            pad;

  assign serial_data_out = shift_reg[CFG_WIDTH-1];

  // Control FSM: default load, serial shift, commit/error and restore handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      shift_reg    <= '0;
      config_reg   <= '0;
      bit_cnt      <= '0;
      config_valid <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_INIT: begin
          shift_reg    <= gpio_defaults;
          config_reg   <= gpio_defaults;
          config_valid <= 1'b1;
          state        <= S_IDLE;
        end
        S_IDLE, S_SHIFT: begin
          if (restore) begin
            shift_reg  <= gpio_defaults;
            config_reg <= gpio_defaults;
            bit_cnt    <= '0;
            load_error <= 1'b0;
            state      <= S_IDLE;
          end else if (load_strobe) begin
            // Only a stream of exactly CFG_WIDTH bits is a complete word
            if (bit_cnt == CNT_FULL) begin
              config_reg <= shift_reg;
              load_done  <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else if (shift_en) begin
            shift_reg <= {shift_reg[CFG_WIDTH-2:0], serial_data_in};
            if (state == S_IDLE) begin
              bit_cnt <= CNT_WIDTH'(1);
            end else if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CNT_WIDTH'(1);
            end
            state <= S_SHIFT;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  gpio_config_decode u_decode (
    .config_valid (config_valid),
    .config_reg   (config_reg),
    .pad          (pad),
    .gpio_config  (gpio_config)
  );

  assign mgmt_ena         = pad.mgmt_ena;
  assign gpio_outenb      = pad.outenb;
  assign gpio_holdover    = pad.holdover;
  assign gpio_inenb       = pad.inenb;
  assign gpio_ib_mode_sel = pad.ib_mode_sel;
  assign gpio_ana_en      = pad.ana_en;
  assign gpio_ana_sel     = pad.ana_sel;
  assign gpio_ana_pol     = pad.ana_pol;
  assign gpio_slow_sel    = pad.slow_sel;
  assign gpio_vtrip_sel   = pad.vtrip_sel;
  assign gpio_dm          = pad.dm;

endmodule

// File: tb/tb_gpio_config_shifter.sv
// Directed bench for gpio_config_shifter: reset, commit, short/long streams, priority, async reset.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_gpio_config_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] gpio_defaults = 13'h0402;
  logic        serial_data_in = 1'b0;
  logic        shift_en = 1'b0;
  logic        load_strobe = 1'b0;
  logic        restore = 1'b0;
  logic        serial_data_out;
  logic [12:0] gpio_config;
  logic        config_valid, load_done, load_error;
  logic        mgmt_ena, gpio_outenb, gpio_holdover, gpio_inenb, gpio_ib_mode_sel;
  logic        gpio_ana_en, gpio_ana_sel, gpio_ana_pol, gpio_slow_sel, gpio_vtrip_sel;
  logic [2:0]  gpio_dm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_config_shifter dut (
    .clk              (clk),
    .reset            (reset),
    .gpio_defaults    (gpio_defaults),
    .serial_data_in   (serial_data_in),
    .shift_en         (shift_en),
    .load_strobe      (load_strobe),
    .restore          (restore),
    .serial_data_out  (serial_data_out),
    .gpio_config      (gpio_config),
    .config_valid     (config_valid),
    .load_done        (load_done),
    .load_error       (load_error),
    .mgmt_ena         (mgmt_ena),
    .gpio_outenb      (gpio_outenb),
    .gpio_holdover    (gpio_holdover),
    .gpio_inenb       (gpio_inenb),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_ana_en      (gpio_ana_en),
    .gpio_ana_sel     (gpio_ana_sel),
    .gpio_ana_pol     (gpio_ana_pol),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_dm          (gpio_dm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift the low n bits of w, most significant first
  task automatic shift_bits(input logic [12:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_data_in = w[i];
      shift_en = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    serial_data_in = 1'b0;
  endtask

  task automatic pulse_load();
    load_strobe = 1'b1;
    tick();
    load_strobe = 1'b0;
  endtask

  task automatic pulse_restore();
    restore = 1'b1;
    tick();
    restore = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (config_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", config_valid); end
    checks++; if (gpio_outenb !== 1'b1) begin failures++; $display("FAIL rst_outenb got=%b exp=1", gpio_outenb); end
    checks++; if (gpio_inenb !== 1'b1) begin failures++; $display("FAIL rst_inenb got=%b exp=1", gpio_inenb); end
    checks++; if (gpio_dm !== 3'b000) begin failures++; $display("FAIL rst_dm got=%b exp=000", gpio_dm); end
    checks++; if (gpio_config !== 13'h0000) begin failures++; $display("FAIL rst_config got=%h exp=0000", gpio_config); end
    checks++; if (serial_data_out !== 1'b0) begin failures++; $display("FAIL rst_sdo got=%b exp=0", serial_data_out); end
    checks++; if ({load_done, load_error} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {load_done, load_error}); end
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL init_config got=%h exp=0402", gpio_config); end
    checks++; if (config_valid !== 1'b1) begin failures++; $display("FAIL init_valid got=%b exp=1", config_valid); end
    checks++; if (gpio_outenb !== 1'b1) begin failures++; $display("FAIL init_outenb got=%b exp=1", gpio_outenb); end
    checks++; if (gpio_dm !== 3'b001) begin failures++; $display("FAIL init_dm got=%b exp=001", gpio_dm); end
    checks++; if (gpio_inenb !== 1'b0) begin failures++; $display("FAIL init_inenb got=%b exp=0", gpio_inenb); end
  endtask

  task automatic test_load_good();
    shift_bits(13'h1803, 13);
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL pre_commit got=%h exp=0402", gpio_config); end
    pulse_load();
    checks++; if (gpio_config !== 13'h1803) begin failures++; $display("FAIL good_config got=%h exp=1803", gpio_config); end
    checks++; if (mgmt_ena !== 1'b1) begin failures++; $display("FAIL good_mgmt got=%b exp=1", mgmt_ena); end
    checks++; if (gpio_outenb !== 1'b1) begin failures++; $display("FAIL good_outenb got=%b exp=1", gpio_outenb); end
    checks++; if (gpio_dm !== 3'b110) begin failures++; $display("FAIL good_dm got=%b exp=110", gpio_dm); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL good_done got=%b exp=1", load_done); end
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL good_err got=%b exp=0", load_error); end
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL good_done_pulse got=%b exp=0", load_done); end
  endtask

  task automatic test_short_load();
    pulse_restore();
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL short_restore got=%h exp=0402", gpio_config); end
    shift_bits(13'h1803, 12);
    pulse_load();
    checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", load_error); end
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL short_config got=%h exp=0402", gpio_config); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL short_done got=%b exp=0", load_done); end
    shift_bits(13'h1803, 13);
    pulse_load();
    checks++; if (gpio_config !== 13'h1803) begin failures++; $display("FAIL short_retry got=%h exp=1803", gpio_config); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL short_retry_done got=%b exp=1", load_done); end
    checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL short_sticky got=%b exp=1", load_error); end
  endtask

  task automatic test_saturate();
    logic [12:0] def;
    logic        exp_bit;
    def = 13'h0402;
    pulse_restore();
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL sat_restore_err got=%b exp=0", load_error); end
    checks++; if (serial_data_out !== def[12]) begin failures++; $display("FAIL sat_sdo0 got=%b exp=%b", serial_data_out, def[12]); end
    for (int k = 1; k <= 20; k++) begin
      serial_data_in = 1'b0;
      shift_en = 1'b1;
      tick();
      exp_bit = (k < 13) ? def[12 - k] : 1'b0;
      checks++; if (serial_data_out !== exp_bit) begin failures++; $display("FAIL sat_sdo shift=%0d got=%b exp=%b", k, serial_data_out, exp_bit); end
    end
    shift_en = 1'b0;
    pulse_load();
    checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL sat20_err got=%b exp=1", load_error); end
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL sat20_config got=%h exp=0402", gpio_config); end
    // 29 shifts would wrap a 4-bit counter to 13 without saturation
    pulse_restore();
    shift_bits(13'h0000, 13);
    shift_bits(13'h0000, 13);
    shift_bits(13'h0000, 3);
    pulse_load();
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL sat29_config got=%h exp=0402", gpio_config); end
    checks++; if ({load_done, load_error} !== 2'b01) begin failures++; $display("FAIL sat29_flags got=%b exp=01", {load_done, load_error}); end
  endtask

  task automatic test_restore_priority();
    shift_bits(13'h1FFF, 7);
    restore = 1'b1;
    load_strobe = 1'b1;
    tick();
    restore = 1'b0;
    load_strobe = 1'b0;
    checks++; if (gpio_config !== 13'h0402) begin failures++; $display("FAIL prio_config got=%h exp=0402", gpio_config); end
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL prio_err got=%b exp=0", load_error); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL prio_done got=%b exp=0", load_done); end
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL prio_done_late got=%b exp=0", load_done); end
    shift_bits(13'h0A55, 13);
    pulse_load();
    checks++; if (gpio_config !== 13'h0A55) begin failures++; $display("FAIL prio_next got=%h exp=0a55", gpio_config); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL prio_next_done got=%b exp=1", load_done); end
    checks++; if (gpio_dm !== 3'b010) begin failures++; $display("FAIL prio_dm got=%b exp=010", gpio_dm); end
    checks++; if ({gpio_holdover, gpio_vtrip_sel, gpio_ana_sel, gpio_ib_mode_sel} !== 4'b1111) begin failures++; $display("FAIL prio_fields_hi got=%b exp=1111", {gpio_holdover, gpio_vtrip_sel, gpio_ana_sel, gpio_ib_mode_sel}); end
    checks++; if ({gpio_outenb, gpio_inenb, gpio_ana_en, gpio_ana_pol, gpio_slow_sel} !== 5'b00000) begin failures++; $display("FAIL prio_fields_lo got=%b exp=00000", {gpio_outenb, gpio_inenb, gpio_ana_en, gpio_ana_pol, gpio_slow_sel}); end
  endtask

  task automatic test_back_to_back();
    // Load beats shift: the word committed is the one already shifted, and no extra bit enters
    shift_bits(13'h0A55, 13);
    serial_data_in = 1'b1;
    shift_en = 1'b1;
    load_strobe = 1'b1;
    tick();
    shift_en = 1'b0;
    load_strobe = 1'b0;
    serial_data_in = 1'b0;
    checks++; if (gpio_config !== 13'h0A55) begin failures++; $display("FAIL b2b_config got=%h exp=0a55", gpio_config); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", load_done); end
    checks++; if (serial_data_out !== 1'b0) begin failures++; $display("FAIL b2b_noshift got=%b exp=0", serial_data_out); end
    // Stream straight into another word, then an immediate empty load
    shift_bits(13'h1803, 13);
    pulse_load();
    checks++; if (gpio_config !== 13'h1803) begin failures++; $display("FAIL b2b_second got=%h exp=1803", gpio_config); end
    pulse_load();
    checks++; if ({load_done, load_error} !== 2'b01) begin failures++; $display("FAIL b2b_empty_flags got=%b exp=01", {load_done, load_error}); end
    checks++; if (gpio_config !== 13'h1803) begin failures++; $display("FAIL b2b_empty_config got=%h exp=1803", gpio_config); end
  endtask

  task automatic test_async_reset();
    shift_bits(13'h1FFF, 5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (config_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", config_valid); end
    checks++; if (gpio_config !== 13'h0000) begin failures++; $display("FAIL arst_config got=%h exp=0000", gpio_config); end
    checks++; if ({gpio_outenb, gpio_inenb, mgmt_ena, gpio_dm} !== 6'b110000) begin failures++; $display("FAIL arst_safe got=%b exp=110000", {gpio_outenb, gpio_inenb, mgmt_ena, gpio_dm}); end
    checks++; if ({serial_data_out, load_error} !== 2'b00) begin failures++; $display("FAIL arst_sdo_err got=%b exp=00", {serial_data_out, load_error}); end
    gpio_defaults = 13'h1ABC;
    #10;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checks++; if (gpio_config !== 13'h1ABC) begin failures++; $display("FAIL arst_reload got=%h exp=1abc", gpio_config); end
    checks++; if (config_valid !== 1'b1) begin failures++; $display("FAIL arst_revalid got=%b exp=1", config_valid); end
    gpio_defaults = 13'h0000;
    tick();
    tick();
    checks++; if (gpio_config !== 13'h1ABC) begin failures++; $display("FAIL defaults_static got=%h exp=1abc", gpio_config); end
  endtask

  initial begin
    test_reset();
    test_load_good();
    test_short_load();
    test_saturate();
    test_restore_priority();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_config_shifter.md
Name: gpio_config_shifter

Overview:
Per-pad GPIO configuration consumer. It receives the 13-bit mask-programmed default word, loads that word after reset, and accepts a serial reprogramming stream from housekeeping. It commits a new word only after exactly CFG_WIDTH bits have been shifted in, and drives decoded pad-control fields to the pad. It sits between the per-pad defaults constant block and the pad, and its serial output daisy-chains to the next pad.

Parameters:
CFG_WIDTH, 13, configuration word width.
CNT_WIDTH, 4, bit-counter width; must satisfy 2^CNT_WIDTH-1 > CFG_WIDTH.

Ports:
clk  input  1  single clock for all state.
reset  input  1  asynchronous, active-high reset.
VPWR / VGND  inout  1  power pins, present only under USE_POWER_PINS; not used by logic.
gpio_defaults  input  CFG_WIDTH  default word from the defaults block; static.
serial_data_in  input  1  serial configuration bit.
shift_en  input  1  one-cycle strobe; shift serial_data_in in.
load_strobe  input  1  one-cycle strobe; commit the shift register.
restore  input  1  one-cycle strobe; reload the defaults.
serial_data_out  output  1  shift_reg[CFG_WIDTH-1], feeds the next pad in the chain.
gpio_config  output  CFG_WIDTH  committed configuration word.
config_valid  output  1  high once the defaults have been loaded.
load_done  output  1  one-cycle pulse after a successful commit.
load_error  output  1  sticky flag for a bad bit count at commit.
mgmt_ena, gpio_outenb, gpio_holdover, gpio_inenb, gpio_ib_mode_sel, gpio_ana_en, gpio_ana_sel, gpio_ana_pol, gpio_slow_sel, gpio_vtrip_sel  output  1 each  decoded from config bits 0..9.
gpio_dm  output  3  drive mode, config bits 12:10.

Behaviour:
- Reset asserted (async): state=S_INIT, shift_reg=0, config_reg=0, bit_cnt=0, config_valid=0, load_done=0, load_error=0, so serial_data_out=0.
- Safe gating while config_valid=0: gpio_outenb=1, gpio_inenb=1, all other decoded outputs 0, gpio_dm=000, gpio_config=0.
- FSM states: S_INIT, S_IDLE, S_SHIFT.
- S_INIT (first clk edge after reset deasserts): shift_reg and config_reg <= gpio_defaults, config_valid<=1, go to S_IDLE. All strobes are ignored in S_INIT.
- Shift operation: shift_reg <= {shift_reg[CFG_WIDTH-2:0], serial_data_in}; bit_cnt increments and saturates at 2^CNT_WIDTH-1. Data is MSB first, so the first bit shifted lands in bit CFG_WIDTH-1 after 13 shifts.
- S_IDLE + shift_en: bit_cnt<=1, shift, go to S_SHIFT. S_SHIFT + shift_en: shift, increment bit_cnt.
- load_strobe in S_IDLE or S_SHIFT:
  - If bit_cnt==CFG_WIDTH: config_reg<=shift_reg and load_done=1 on the next cycle.
  - Otherwise: load_error<=1 and config_reg is unchanged.
  - In both cases bit_cnt<=0 and state goes to S_IDLE.
- load_strobe in S_IDLE therefore always has bit_cnt=0 and errors.
- restore (S_IDLE or S_SHIFT): shift_reg and config_reg <= gpio_defaults, bit_cnt<=0, load_error<=0, go to S_IDLE.
- Priority for simultaneous strobes: restore > load_strobe > shift_en. The lower-priority strobe is dropped entirely; no shift occurs in a load cycle.
- load_done: registered, high exactly one cycle, never high together with a new load_error set.
- Latency: committed config appears on the decoded outputs one cycle after the load_strobe edge. Decode is combinational from config_reg.
- gpio_defaults is sampled only in S_INIT and on restore; later changes have no effect.
- Reset asserted mid-shift aborts immediately. config_valid drops asynchronously and outputs return to the safe values.

Decomposition:
- Shared package gpio_cfg_pkg:
  - CFG_WIDTH=13.
  - Bit-index constants: CFG_MGMT_ENA=0, CFG_OUTENB=1, CFG_HOLDOVER=2, CFG_INENB=3, CFG_IB_MODE=4, CFG_ANA_EN=5, CFG_ANA_SEL=6, CFG_ANA_POL=7, CFG_SLOW=8, CFG_VTRIP=9, CFG_DM_LSB=10, DM_WIDTH=3.
  - Default word 13'h0402.
  - FSM state encoding.
- Sub-module gpio_config_decode: combinational field extraction plus the config_valid safe gating.

Test Plan:
1. gpio_defaults=13'h0402; hold reset, then release. -> During reset: config_valid=0, gpio_outenb=1, gpio_dm=000. After the second edge: gpio_config=0x0402, gpio_outenb=1, gpio_dm=001, config_valid=1.
2. Shift 13'h1803 MSB first (13 shift_en), then load_strobe. -> Next cycle: gpio_config=0x1803, mgmt_ena=1, gpio_outenb=1, gpio_dm=110; load_done high for exactly 1 cycle; load_error=0.
3. Shift 12 bits, then load_strobe. -> load_error=1 (sticky), gpio_config stays 0x0402. A following correct 13-bit load succeeds and load_error stays 1.
4. From the defaults state, shift 20 bits of 0. -> serial_data_out emits 0x0402 MSB first on the first 13 shifts (0,0,1,0,0,0,0,0,0,0,0,1,0), then 0. bit_cnt saturates; load_strobe -> load_error=1.
5. Shift 7 bits, then restore together with load_strobe. -> Restore wins: gpio_config=0x0402, load_error cleared, no load_done. Next 13-bit load succeeds.
6. Assert reset mid-shift after a committed 0x1803. -> config_valid=0 and safe outputs appear without waiting for clk. After release, the config returns to the gpio_defaults value.
